// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier.
// The is_signed wire exists only when MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
`ifdef MULT_SIGNED_EN
   logic                 is_signed;
`endif
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

`ifdef MULT_SIGNED_EN
   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, product, busy
   );
   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, product, busy
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN to add two's complement support via is_signed.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   seq_multiplier_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic                 neg_q, neg_d, neg_in;
   logic [2*WIDTH-1:0]   sum;

   // Magnitudes are taken at accept so the datapath stays unsigned.
   always_comb begin
      a_mag  = bus.a;
      b_mag  = bus.b;
      neg_in = 1'b0;
`ifdef MULT_SIGNED_EN
      if (bus.is_signed) begin
         if (bus.a[WIDTH-1]) a_mag = -bus.a;
         if (bus.b[WIDTH-1]) b_mag = -bus.b;
         neg_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
`endif
   end

   assign sum = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      neg_d   = neg_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = a_mag;
               b_d     = b_mag;
               neg_d   = neg_in;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (b_q[cnt_q]) acc_d = sum;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               cnt_d   = '0;
               state_d = DONE;
               if (neg_q) acc_d = -acc_d;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               acc_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.product   = (state_q == DONE) ? acc_q : '0;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks for seq_multiplier at WIDTH=32 and WIDTH=8.
// Signed vectors are compiled in with MULT_SIGNED_EN.
module tb_seq_multiplier;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   seq_multiplier_if #(.WIDTH(32)) i32 ();
   seq_multiplier_if #(.WIDTH(8))  i8 ();

   seq_multiplier #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));
   seq_multiplier #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, output logic [63:0] prod,
                        output int lat, output logic ok);
      int t;
      ok = 1'b1;
      t  = 0;
      while (!i32.in_ready && t < 100) begin
         tick();
         t++;
      end
      i32.in_valid = 1'b1;
      i32.a        = a;
      i32.b        = b;
`ifdef MULT_SIGNED_EN
      i32.is_signed = sgn;
`else
      if (sgn) ok = 1'b0;
`endif
      tick();
      i32.in_valid = 1'b0;
      i32.a        = ~a;
      i32.b        = 32'h5A5A_5A5A;
`ifdef MULT_SIGNED_EN
      i32.is_signed = ~sgn;
`endif
      lat = 0;
      while (!i32.out_valid && lat < 100) begin
         if (i32.in_ready || !i32.busy || i32.product != 64'd0) ok = 1'b0;
         tick();
         lat++;
      end
      prod          = i32.product;
      i32.out_ready = 1'b1;
      tick();
      i32.out_ready = 1'b0;
      if (!i32.in_ready || i32.busy || i32.out_valid) ok = 1'b0;
      if (i32.product != 64'd0) ok = 1'b0;
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] prod, output int lat);
      int t;
      t = 0;
      while (!i8.in_ready && t < 50) begin
         tick();
         t++;
      end
      i8.in_valid = 1'b1;
      i8.a        = a;
      i8.b        = b;
      tick();
      i8.in_valid = 1'b0;
      i8.a        = ~a;
      i8.b        = ~b;
      lat = 0;
      while (!i8.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      prod         = i8.product;
      i8.out_ready = 1'b1;
      tick();
      i8.out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] p;
      logic [15:0] p8;
      int          lat;
      logic        ok;
      logic [7:0]  ra, rb;
      n_cmp  = 0;
      n_fail = 0;

      tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
      tbl.push_back('{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0});
      tbl.push_back('{32'd6,         32'd7,         1'b0, 64'd42});
      tbl.push_back('{32'h8000_0000, 32'd2,         1'b0, 64'h1_0000_0000});
      tbl.push_back('{32'h1234_5678, 32'h10,        1'b0, 64'h1_2345_6780});
      tbl.push_back('{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'hFFFE_0001});
      tbl.push_back('{32'hDEAD_BEEF, 32'd1,         1'b0, 64'hDEAD_BEEF});
      tbl.push_back('{32'hFFFF_FFFD, 32'd7,         1'b0, 64'h6_FFFF_FFEB});
`ifdef MULT_SIGNED_EN
      tbl.push_back('{32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
      tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
      tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1});
      tbl.push_back('{32'd5,         32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6});
      i32.is_signed = 1'b0;
`endif

      rst_n         = 1'b0;
      i32.in_valid  = 1'b0;
      i32.a         = '0;
      i32.b         = '0;
      i32.out_ready = 1'b0;
      i8.in_valid   = 1'b0;
      i8.a          = '0;
      i8.b          = '0;
      i8.out_ready  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", {63'd0, i32.in_ready}, 64'd1);
      chk("rst_busy", {63'd0, i32.busy}, 64'd0);
      chk("rst_out_valid", {63'd0, i32.out_valid}, 64'd0);
      chk("rst_product", i32.product, 64'd0);

      foreach (tbl[i]) begin
         run32(tbl[i].a, tbl[i].b, tbl[i].sgn, p, lat, ok);
         chk($sformatf("vec%0d_product", i), p, tbl[i].exp);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
         chk($sformatf("vec%0d_handshake", i), {63'd0, ok}, 64'd1);
      end

      // Result held in DONE while consumer stalls and new operands wait.
      i32.in_valid = 1'b1;
      i32.a        = 32'h0001_0000;
      i32.b        = 32'd3;
      tick();
      i32.in_valid = 1'b0;
      lat = 0;
      while (!i32.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("hold_latency", 64'(lat), 64'd32);
      i32.in_valid = 1'b1;
      i32.a        = 32'd5;
      i32.b        = 32'd5;
      ok           = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (i32.product != 64'h3_0000 || !i32.out_valid || i32.in_ready)
            ok = 1'b0;
         tick();
      end
      chk("hold_stable", {63'd0, ok}, 64'd1);
      i32.out_ready = 1'b1;
      tick();
      i32.out_ready = 1'b0;
      chk("hold_idle_ready", {63'd0, i32.in_ready}, 64'd1);
      tick();
      i32.in_valid = 1'b0;
      chk("hold_next_accepted", {63'd0, i32.busy}, 64'd1);
      lat = 0;
      while (!i32.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("hold_next_latency", 64'(lat), 64'd32);
      chk("hold_next_product", i32.product, 64'd25);
      i32.out_ready = 1'b1;
      tick();
      i32.out_ready = 1'b0;

      // Reset in the middle of CALC aborts the operation silently.
      i32.in_valid = 1'b1;
      i32.a        = 32'h1111_1111;
      i32.b        = 32'hFFFF_FFFF;
      tick();
      i32.in_valid = 1'b0;
      repeat (15) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_in_ready", {63'd0, i32.in_ready}, 64'd1);
      chk("abort_busy", {63'd0, i32.busy}, 64'd0);
      ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (i32.out_valid || i32.product != 64'd0) ok = 1'b0;
         tick();
      end
      chk("abort_no_pulse", {63'd0, ok}, 64'd1);
      run32(32'd6, 32'd7, 1'b0, p, lat, ok);
      chk("abort_next_product", p, 64'd42);
      chk("abort_next_latency", 64'(lat), 64'd32);

      chk("w8_rst_in_ready", {63'd0, i8.in_ready}, 64'd1);
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (k == 0) begin
            ra = 8'hFF;
            rb = 8'hFF;
         end
         run8(ra, rb, p8, lat);
         chk($sformatf("w8_%0d_product", k), {48'd0, p8},
             64'({8'd0, ra} * {8'd0, rb}));
         chk($sformatf("w8_%0d_latency", k), 64'(lat), 64'd8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
